// File: rtl/jacobi_pkg.sv
// Shared types and helpers for the jacobi sweep controller and its datapath.
package jacobi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_NU    = 10;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_EXPON = 3;
    localparam int DEF_ITW   = 16;

    // Widest packed vector / word the word() helper can address.
    localparam int VEC_MAX  = 1024;
    localparam int WORD_MAX = 32;

    // Extract word idx (w bits wide) from a packed vector, zero-extended.
    function automatic logic [WORD_MAX-1:0] word(
        input logic [VEC_MAX-1:0] vec,
        input logic [31:0]        idx,
        input logic [31:0]        w
    );
        logic [WORD_MAX-1:0] mask;
        if (w >= 32'd32) begin
            mask = {WORD_MAX{1'b1}};
        end else begin
            mask = (32'd1 << w) - 32'd1;
        end
        return WORD_MAX'(vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/jacobi_sweep.sv
// One combinational jacobi sweep: interior words average their neighbours
// plus the source term (mod 2^WIDTH, then halved); end words pass through.
module jacobi_sweep
    import jacobi_pkg::*;
#(
    parameter int NU    = DEF_NU,
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXPON = DEF_EXPON
) (
    input  logic [NU*WIDTH-1:0] u,
    output logic [NU*WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] H2 = {{(WIDTH-1){1'b0}}, 1'b1} << EXPON;

    for (genvar i = 0; i < NU; i++) begin : g_word
        if (i == 0 || i == NU - 1) begin : g_edge
            assign nxt[i*WIDTH +: WIDTH] = u[i*WIDTH +: WIDTH];
        end else begin : g_int
            logic [WIDTH-1:0] sum_s;
            // Neighbour sum wraps naturally at WIDTH bits before the halving.
            always_comb begin
                sum_s = H2
                      + WIDTH'(word(VEC_MAX'(u), 32'(i - 1), 32'(WIDTH)))
                      + WIDTH'(word(VEC_MAX'(u), 32'(i + 1), 32'(WIDTH)));
            end
            assign nxt[i*WIDTH +: WIDTH] = {1'b0, sum_s[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/jacobi_ctrl.sv
// Sequencer around one jacobi sweep: host load/readback of the solution
// vector, one sweep per clock, stop on iteration cap or exact fixed point.
module jacobi_ctrl
    import jacobi_pkg::*;
#(
    parameter int NU    = DEF_NU,
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXPON = DEF_EXPON,
    parameter int ITW   = DEF_ITW,
    parameter int AW    = $clog2(NU)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             start,
    input  logic [ITW-1:0]   max_iters,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic [ITW-1:0]   iter_count
);

    localparam logic [31:0]    NU_U   = 32'(NU);
    localparam logic [ITW-1:0] ONE_IT = {{(ITW-1){1'b0}}, 1'b1};

    state_t               state_r, state_nxt_s;
    logic [NU*WIDTH-1:0]  vec_r, sweep_s;
    logic [ITW-1:0]       lim_r, iter_r;
    logic                 conv_r, busy_r, done_r;
    logic [WIDTH-1:0]     rd_data_r, rd_word_s;
    logic                 start_ok_s, wr_ok_s, fixed_s, at_lim_s;
    logic                 busy_nxt_s, done_nxt_s;

    jacobi_sweep #(.NU(NU), .WIDTH(WIDTH), .EXPON(EXPON)) u_sweep (
        .u   (vec_r),
        .nxt (sweep_s)
    );

    // Qualify host requests and evaluate the stop conditions for this cycle.
    always_comb begin
        start_ok_s = (state_r == ST_IDLE) && start;
        wr_ok_s    = (state_r == ST_IDLE) && wr_en && (32'(wr_addr) < NU_U);
        fixed_s    = (sweep_s == vec_r);
        at_lim_s   = ((iter_r + ONE_IT) == lim_r);
        if (32'(rd_addr) < NU_U) begin
            rd_word_s = WIDTH'(word(VEC_MAX'(vec_r), 32'(rd_addr), 32'(WIDTH)));
        end else begin
            rd_word_s = {WIDTH{1'b0}};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero limit skips RUN, fixed point beats the limit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    if (max_iters == {ITW{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fixed_s || at_lim_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the upcoming state.
    always_comb begin
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Vector, counter, limit and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_r     <= {(NU*WIDTH){1'b0}};
            lim_r     <= {ITW{1'b0}};
            iter_r    <= {ITW{1'b0}};
            conv_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rd_data_r <= {WIDTH{1'b0}};
        end else begin
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            rd_data_r <= rd_word_s;
            // A write in the start cycle lands before the first sweep.
            for (int i = 0; i < NU; i++) begin
                if (wr_ok_s && (wr_addr == AW'(i))) begin
                    vec_r[i*WIDTH +: WIDTH] <= wr_data;
                end
            end
            if (start_ok_s) begin
                lim_r  <= max_iters;
                iter_r <= {ITW{1'b0}};
                conv_r <= 1'b0;
            end else if (state_r == ST_RUN) begin
                if (fixed_s) begin
                    conv_r <= 1'b1;
                end else begin
                    vec_r  <= sweep_s;
                    iter_r <= iter_r + ONE_IT;
                end
            end
        end
    end

    assign rd_data    = rd_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign converged  = conv_r;
    assign iter_count = iter_r;

endmodule

// File: tb/tb_jacobi_ctrl.sv
// Self-checking bench for jacobi_ctrl: one NU=10 and one NU=3 instance
// share stimulus; sel picks which one is observed and modelled.
module tb_jacobi_ctrl;

    localparam int H2 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, wr_en, start;
    logic [3:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic [15:0] max_iters;

    logic [7:0]  rd10, rd3;
    logic        busy10, done10, conv10, busy3, done3, conv3;
    logic [15:0] it10, it3;

    jacobi_ctrl #(.NU(10), .WIDTH(8), .EXPON(3), .ITW(16)) dut10 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd10),
        .start(start), .max_iters(max_iters), .busy(busy10),
        .done(done10), .converged(conv10), .iter_count(it10)
    );

    jacobi_ctrl #(.NU(3), .WIDTH(8), .EXPON(3), .ITW(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr[1:0]),
        .wr_data(wr_data), .rd_addr(rd_addr[1:0]), .rd_data(rd3),
        .start(start), .max_iters(max_iters), .busy(busy3),
        .done(done3), .converged(conv3), .iter_count(it3)
    );

    int sel = 0;
    logic [7:0]  rd_s;
    logic        busy_s, done_s, conv_s;
    logic [15:0] it_s;
    assign rd_s   = (sel == 1) ? rd3   : rd10;
    assign busy_s = (sel == 1) ? busy3 : busy10;
    assign done_s = (sel == 1) ? done3 : done10;
    assign conv_s = (sel == 1) ? conv3 : conv10;
    assign it_s   = (sel == 1) ? it3   : it10;

    int checks = 0;
    int errors = 0;
    int nu = 10;
    int mv[10];
    int sweep2_exp[10] = '{0, 6, 8, 8, 8, 8, 8, 8, 6, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; start = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
        rd_addr = 4'd0; max_iters = 16'd0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) mv[i] = 0;
    endtask

    task automatic write_word(input int a, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'(d);
        tick();
        wr_en = 1'b0;
        if (a < nu) mv[a] = d & 255;
    endtask

    task automatic read_word(input int a, output int d);
        rd_addr = 4'(a);
        tick();
        d = int'(rd_s);
    endtask

    // Reference: apply the sweep rule on plain integers until fixed point or limit.
    function automatic void model_run(input int lim, output int it, output int cv);
        int nx[10];
        bit same;
        it = 0;
        cv = 0;
        for (int k = 0; k < lim; k++) begin
            for (int i = 0; i < nu; i++) begin
                if (i == 0 || i == nu - 1) nx[i] = mv[i];
                else nx[i] = ((H2 + mv[i-1] + mv[i+1]) % 256) / 2;
            end
            same = 1'b1;
            for (int i = 0; i < nu; i++) if (nx[i] != mv[i]) same = 1'b0;
            if (same) begin
                cv = 1;
                break;
            end
            for (int i = 0; i < nu; i++) mv[i] = nx[i];
            it++;
        end
    endfunction

    // Start a run (optionally with a same-cycle write) and watch it to the end.
    task automatic run(input int lim, input bit do_wr, input int wa, input int wd,
                       output int busy_n, output int done_n, output int done_last);
        max_iters = 16'(lim);
        start = 1'b1;
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = 4'(wa); wr_data = 8'(wd);
            if (wa < nu) mv[wa] = wd & 255;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        busy_n = 0; done_n = 0; done_last = 0;
        while (busy_s === 1'b1 && busy_n < 3000) begin
            busy_n++;
            if (done_s === 1'b1) begin
                done_n++;
                done_last = busy_n;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int d;
        sel = 0; nu = 10;
        do_reset();
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done got %0d want 0", done_s); end
        checks++; if (conv_s !== 1'b0) begin errors++; $display("FAIL reset_conv got %0d want 0", conv_s); end
        checks++; if (it_s !== 16'd0) begin errors++; $display("FAIL reset_iter got %0d want 0", it_s); end
        checks++; if (rd_s !== 8'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rd_s); end
        for (int i = 0; i < 10; i++) begin
            read_word(i, d);
            checks++; if (d != 0) begin errors++; $display("FAIL reset_word[%0d] got %0d want 0", i, d); end
        end
    endtask

    task automatic test_two_sweeps();
        int bn, dn, dl, d;
        sel = 0; nu = 10;
        do_reset();
        run(2, 1'b0, 0, 0, bn, dn, dl);
        checks++; if (it_s !== 16'd2) begin errors++; $display("FAIL sweep2_iter got %0d want 2", it_s); end
        checks++; if (conv_s !== 1'b0) begin errors++; $display("FAIL sweep2_conv got %0d want 0", conv_s); end
        checks++; if (bn != 3) begin errors++; $display("FAIL sweep2_busy_cycles got %0d want 3", bn); end
        checks++; if (dn != 1 || dl != 3) begin errors++; $display("FAIL sweep2_done got count %0d at %0d want 1 at 3", dn, dl); end
        for (int i = 0; i < 10; i++) begin
            read_word(i, d);
            checks++; if (d != sweep2_exp[i]) begin errors++; $display("FAIL sweep2_word[%0d] got %0d want %0d", i, d, sweep2_exp[i]); end
        end
    endtask

    task automatic test_fixed_point();
        int bn, dn, dl, d;
        sel = 1; nu = 3;
        do_reset();
        run(100, 1'b0, 0, 0, bn, dn, dl);
        checks++; if (it_s !== 16'd1) begin errors++; $display("FAIL fixed_iter got %0d want 1", it_s); end
        checks++; if (conv_s !== 1'b1) begin errors++; $display("FAIL fixed_conv got %0d want 1", conv_s); end
        checks++; if (bn != 3 || dn != 1) begin errors++; $display("FAIL fixed_busy got %0d/%0d want 3/1", bn, dn); end
        read_word(1, d);
        checks++; if (d != 4) begin errors++; $display("FAIL fixed_word1 got %0d want 4", d); end
    endtask

    task automatic test_wrap_and_zero_limit();
        int bn, dn, dl, d;
        sel = 1; nu = 3;
        do_reset();
        write_word(0, 255); write_word(1, 0); write_word(2, 255);
        run(5, 1'b0, 0, 0, bn, dn, dl);
        read_word(1, d);
        checks++; if (d != 3) begin errors++; $display("FAIL wrap_word1 got %0d want 3", d); end
        checks++; if (it_s !== 16'd1 || conv_s !== 1'b1) begin errors++; $display("FAIL wrap_status got iter %0d conv %0d want 1 1", it_s, conv_s); end
        read_word(2, d);
        checks++; if (d != 255) begin errors++; $display("FAIL wrap_word2 got %0d want 255", d); end
        run(0, 1'b0, 0, 0, bn, dn, dl);
        checks++; if (bn != 1 || dn != 1 || dl != 1) begin errors++; $display("FAIL zlim_timing got busy %0d done %0d at %0d want 1 1 1", bn, dn, dl); end
        checks++; if (it_s !== 16'd0 || conv_s !== 1'b0) begin errors++; $display("FAIL zlim_status got iter %0d conv %0d want 0 0", it_s, conv_s); end
        read_word(1, d);
        checks++; if (d != 3) begin errors++; $display("FAIL zlim_word1 got %0d want 3", d); end
    endtask

    task automatic test_out_of_range();
        int d;
        sel = 0; nu = 10;
        do_reset();
        write_word(12, 77);
        write_word(15, 99);
        write_word(9, 5);
        for (int i = 0; i < 10; i++) begin
            read_word(i, d);
            checks++; if (d != mv[i]) begin errors++; $display("FAIL oob_word[%0d] got %0d want %0d", i, d, mv[i]); end
        end
        read_word(12, d);
        checks++; if (d != 0) begin errors++; $display("FAIL oob_read got %0d want 0", d); end
    endtask

    task automatic test_busy_ignore();
        int bn, extra, d, eit, ecv;
        sel = 0; nu = 10;
        do_reset();
        max_iters = 16'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hAA; start = 1'b1; max_iters = 16'd9;
        tick();
        wr_en = 1'b0; start = 1'b0;
        bn = 0;
        while (busy_s === 1'b1 && bn < 3000) begin bn++; tick(); end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            if (busy_s !== 1'b0 || done_s !== 1'b0) extra++;
            tick();
        end
        model_run(6, eit, ecv);
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_second_run got %0d active cycles want 0", extra); end
        checks++; if (int'(it_s) != eit) begin errors++; $display("FAIL busy_iter got %0d want %0d", it_s, eit); end
        for (int i = 0; i < 10; i++) begin
            read_word(i, d);
            checks++; if (d != mv[i]) begin errors++; $display("FAIL busy_word[%0d] got %0d want %0d", i, d, mv[i]); end
        end
    endtask

    task automatic test_reset_mid_run();
        int bn, dn, dl, d, seen_done, seen_busy;
        sel = 0; nu = 10;
        do_reset();
        rd_addr = 4'd1;
        max_iters = 16'd50; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin errors++; $display("FAIL midrst_hs got busy %0d done %0d want 0 0", busy_s, done_s); end
        checks++; if (it_s !== 16'd0 || conv_s !== 1'b0 || rd_s !== 8'd0) begin errors++; $display("FAIL midrst_out got iter %0d conv %0d rd %0d want 0 0 0", it_s, conv_s, rd_s); end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) mv[i] = 0;
        seen_done = 0; seen_busy = 0;
        for (int k = 0; k < 5; k++) begin
            if (done_s === 1'b1) seen_done++;
            if (busy_s === 1'b1) seen_busy++;
            tick();
        end
        checks++; if (seen_done != 0 || seen_busy != 0) begin errors++; $display("FAIL midrst_quiet got done %0d busy %0d want 0 0", seen_done, seen_busy); end
        for (int i = 0; i < 10; i++) begin
            read_word(i, d);
            checks++; if (d != 0) begin errors++; $display("FAIL midrst_word[%0d] got %0d want 0", i, d); end
        end
        run(2, 1'b0, 0, 0, bn, dn, dl);
        checks++; if (it_s !== 16'd2 || bn != 3 || dn != 1) begin errors++; $display("FAIL midrst_rerun got iter %0d busy %0d done %0d want 2 3 1", it_s, bn, dn); end
        for (int i = 0; i < 10; i++) begin
            read_word(i, d);
            checks++; if (d != sweep2_exp[i]) begin errors++; $display("FAIL midrst_word2[%0d] got %0d want %0d", i, d, sweep2_exp[i]); end
        end
    endtask

    task automatic test_random();
        int bn, dn, dl, d, eit, ecv, lim, nw;
        sel = 0; nu = 10;
        do_reset();
        for (int i = 0; i < 10; i++) write_word(i, int'($urandom_range(0, 255)));
        for (int t = 0; t < 15; t++) begin
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) write_word(int'($urandom_range(0, 11)), int'($urandom_range(0, 255)));
            lim = int'($urandom_range(0, 25));
            run(lim, 1'b1, int'($urandom_range(0, 9)), int'($urandom_range(0, 255)), bn, dn, dl);
            model_run(lim, eit, ecv);
            checks++; if (int'(it_s) != eit || int'(conv_s) != ecv) begin errors++; $display("FAIL rnd%0d_status got iter %0d conv %0d want %0d %0d", t, it_s, conv_s, eit, ecv); end
            checks++; if (bn != eit + ecv + 1 || dn != 1 || dl != bn) begin errors++; $display("FAIL rnd%0d_timing got busy %0d done %0d at %0d want busy %0d one done at end", t, bn, dn, dl, eit + ecv + 1); end
            for (int i = 0; i < 10; i++) begin
                read_word(i, d);
                checks++; if (d != mv[i]) begin errors++; $display("FAIL rnd%0d_word[%0d] got %0d want %0d", t, i, d, mv[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_sweeps();
        test_fixed_point();
        test_wrap_and_zero_limit();
        test_out_of_range();
        test_busy_ignore();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
